sprite_animator: RTL and testbench

- Generalised per-character sprite animation engine for the VGA display path. One instance per character (blue, red, ...).
- Selects the animation sequence from the character state (facing, airborne, moving) and steps frames on a frame-rate strobe with a programmable hold. Horizontal mirroring is done by address transform. Outputs a registered 12-bit pixel plus a transparency flag.
- Sprite image banks live in external ROMs. This block drives bank select and address, and consumes ROM data with 1-cycle read latency.

---
 rtl/sprite_pkg.sv | 39 +++
 rtl/anim_seq_ctrl.sv | 73 +++++++
 rtl/sprite_animator.sv | 86 ++++++++
 tb/tb_sprite_animator.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the per-character sprite animator.
// Sequence ids, state bit positions, bank bases and the transparent key.
package sprite_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_WALK = 2'd1,
        SEQ_JUMP = 2'd2
    } seq_e;

    localparam int ST_FACE = 0;
    localparam int ST_AIR  = 1;
    localparam int ST_MOVE = 2;

    localparam logic [3:0] BASE_IDLE = 4'd0;
    localparam logic [3:0] BASE_WALK = 4'd4;
    localparam logic [3:0] BASE_JUMP = 4'd8;

    localparam logic [11:0] TRANSP_DEF = 12'h0F0;

    // Airborne wins over moving; facing never affects the sequence.
    function automatic seq_e decode_seq(input logic [2:0] st);
        if (st[ST_AIR])
            return SEQ_JUMP;
        else if (st[ST_MOVE])
            return SEQ_WALK;
        else
            return SEQ_IDLE;
    endfunction

    function automatic logic [3:0] bank_base(input seq_e s);
        unique case (s)
            SEQ_WALK: return BASE_WALK;
            SEQ_JUMP: return BASE_JUMP;
            default:  return BASE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/anim_seq_ctrl.sv
// Animation sequencer: sequence decode, change detect, hold counter,
// frame index and the image bank for the next cycle.
module anim_seq_ctrl
    import sprite_pkg::*;
#(
    parameter int N_IDLE = 4,
    parameter int N_WALK = 4,
    parameter int N_JUMP = 1,
    parameter int HOLD   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [2:0] state,
    input  logic       freeze,
    output logic [2:0] frame_idx,
    output logic [3:0] bank_nxt
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [2:0] LAST_IDLE = 3'(N_IDLE - 1);
    localparam logic [2:0] LAST_WALK = 3'(N_WALK - 1);
    localparam logic [2:0] LAST_JUMP = 3'(N_JUMP - 1);

    seq_e seq_q;
    seq_e seq_d;
    logic [2:0] frame_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q     <= SEQ_IDLE;
            frame_idx <= '0;
            hold_q    <= '0;
        end else begin
            seq_q     <= seq_d;
            frame_idx <= frame_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        seq_d   = decode_seq(state);
        frame_d = frame_idx;
        hold_d  = hold_q;
        if (seq_d != seq_q) begin
            frame_d = '0;
            hold_d  = '0;
        end else if (frame_tick && !freeze) begin
            if (hold_q == HOLD_LAST) begin
                hold_d = '0;
                unique case (seq_q)
                    SEQ_JUMP:
                        frame_d = (frame_idx == LAST_JUMP) ?
                                  frame_idx : frame_idx + 3'd1;
                    SEQ_WALK:
                        frame_d = (frame_idx == LAST_WALK) ?
                                  3'd0 : frame_idx + 3'd1;
                    default:
                        frame_d = (frame_idx == LAST_IDLE) ?
                                  3'd0 : frame_idx + 3'd1;
                endcase
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
        // Bank is derived from next-state so it lands with frame_idx.
        bank_nxt = bank_base(seq_d) + {1'b0, frame_d};
    end

endmodule

// File: rtl/sprite_animator.sv
// Per-character sprite engine: animation control, mirrored ROM
// addressing and a 3-stage pixel pipeline with transparency flag.
module sprite_animator
    import sprite_pkg::*;
#(
    parameter int SPR_W  = 47,
    parameter int SPR_H  = 64,
    parameter int ADDR_W = 14,
    parameter int PIX_W  = 12,
    parameter int N_IDLE = 4,
    parameter int N_WALK = 4,
    parameter int N_JUMP = 1,
    parameter int HOLD   = 4,
    parameter logic [PIX_W-1:0] TRANSP = PIX_W'(TRANSP_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic [2:0]        state,
    input  logic              freeze,
    input  logic [5:0]        pix_x,
    input  logic [6:0]        pix_y,
    input  logic              pix_req,
    output logic [3:0]        rom_bank,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_opaque,
    output logic              pix_valid,
    output logic [2:0]        frame_idx
);

    localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(SPR_W);
    localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(SPR_W - 1);

    logic [3:0]        bank_nxt;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] addr_d;
    logic              in_range;
    logic              v1;
    logic              v2;

    anim_seq_ctrl #(
        .N_IDLE (N_IDLE),
        .N_WALK (N_WALK),
        .N_JUMP (N_JUMP),
        .HOLD   (HOLD)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .state      (state),
        .freeze     (freeze),
        .frame_idx  (frame_idx),
        .bank_nxt   (bank_nxt)
    );

    // Facing left reads the stored image right-to-left.
    always_comb begin
        col = state[ST_FACE] ? ADDR_W'(pix_x)
                             : W_LAST - ADDR_W'(pix_x);
        addr_d   = ADDR_W'(pix_y) * W_A + col;
        in_range = (int'(pix_x) < SPR_W) && (int'(pix_y) < SPR_H);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr   <= '0;
            rom_bank   <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            pix_out    <= '0;
            pix_opaque <= 1'b0;
            pix_valid  <= 1'b0;
        end else begin
            rom_addr   <= addr_d;
            rom_bank   <= bank_nxt;
            v1         <= pix_req && in_range;
            v2         <= v1;
            pix_out    <= v2 ? rom_data : '0;
            pix_opaque <= v2 && (rom_data != TRANSP);
            pix_valid  <= v2;
        end
    end

endmodule

// File: tb/tb_sprite_animator.sv
// Directed self-checking bench for sprite_animator.
// Synchronous ROM model returns {bank, addr[7:0]} unless forced.
module tb_sprite_animator;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [2:0]  state;
    logic        freeze;
    logic [5:0]  pix_x;
    logic [6:0]  pix_y;
    logic        pix_req;
    logic [3:0]  rom_bank;
    logic [13:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic [11:0] pix_out;
    logic        pix_opaque;
    logic        pix_valid;
    logic [2:0]  frame_idx;

    logic        use_force = 1'b0;
    logic [11:0] force_val = '0;

    int tests = 0;
    int fails = 0;

    sprite_animator dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .state      (state),
        .freeze     (freeze),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_req    (pix_req),
        .rom_bank   (rom_bank),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_out    (pix_out),
        .pix_opaque (pix_opaque),
        .pix_valid  (pix_valid),
        .frame_idx  (frame_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        rom_data <= use_force ? force_val : {rom_bank, rom_addr[7:0]};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) step();
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (frame_idx !== 3'd0 || rom_bank !== 4'd0) begin
            fails++;
            $display("FAIL reset_frame: frame=%0d bank=%0d want 0 0",
                     frame_idx, rom_bank);
        end
        tests++;
        if (pix_valid !== 1'b0 || pix_opaque !== 1'b0 ||
            pix_out !== 12'h000 || rom_addr !== 14'd0) begin
            fails++;
            $display("FAIL reset_out: v=%b o=%b pix=%h addr=%0d want 0",
                     pix_valid, pix_opaque, pix_out, rom_addr);
        end
    endtask

    task automatic test_idle_loop();
        int exp;
        state = 3'b001;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            ticks(1);
            exp = (k / 4) % 4;
            tests++;
            if (frame_idx !== 3'(exp) || rom_bank !== 4'(exp)) begin
                fails++;
                $display("FAIL idle_tick%0d: frame=%0d bank=%0d want %0d",
                         k, frame_idx, rom_bank, exp);
            end
        end
    endtask

    task automatic test_seq_change();
        state = 3'b001;
        do_reset();
        ticks(10);
        tests++;
        if (frame_idx !== 3'd2) begin
            fails++;
            $display("FAIL pre_change: frame=%0d want 2", frame_idx);
        end
        state = 3'b101;
        ticks(1);
        tests++;
        if (frame_idx !== 3'd0 || rom_bank !== 4'd4) begin
            fails++;
            $display("FAIL walk_entry: frame=%0d bank=%0d want 0 4",
                     frame_idx, rom_bank);
        end
        ticks(3);
        tests++;
        if (frame_idx !== 3'd0) begin
            fails++;
            $display("FAIL walk_hold: frame=%0d want 0", frame_idx);
        end
        ticks(1);
        tests++;
        if (frame_idx !== 3'd1 || rom_bank !== 4'd5) begin
            fails++;
            $display("FAIL walk_step: frame=%0d bank=%0d want 1 5",
                     frame_idx, rom_bank);
        end
    endtask

    task automatic test_jump();
        state = 3'b011;
        step();
        tests++;
        if (frame_idx !== 3'd0 || rom_bank !== 4'd8) begin
            fails++;
            $display("FAIL jump_entry: frame=%0d bank=%0d want 0 8",
                     frame_idx, rom_bank);
        end
        ticks(12);
        tests++;
        if (frame_idx !== 3'd0 || rom_bank !== 4'd8) begin
            fails++;
            $display("FAIL jump_sat: frame=%0d bank=%0d want 0 8",
                     frame_idx, rom_bank);
        end
        state = 3'b001;
        step();
        tests++;
        if (frame_idx !== 3'd0 || rom_bank !== 4'd0) begin
            fails++;
            $display("FAIL landing: frame=%0d bank=%0d want 0 0",
                     frame_idx, rom_bank);
        end
    endtask

    task automatic test_mirror();
        logic [2:0]  st [2];
        logic [13:0] ea [2];
        st[0] = 3'b000; ea[0] = 14'd140;
        st[1] = 3'b001; ea[1] = 14'd94;
        for (int i = 0; i < 2; i++) begin
            state = st[i];
            pix_x = 6'd0;
            pix_y = 7'd2;
            pix_req = 1'b1;
            step();
            pix_req = 1'b0;
            tests++;
            if (rom_addr !== ea[i] || pix_valid !== 1'b0) begin
                fails++;
                $display("FAIL mirror%0d_s1: addr=%0d v=%b want %0d 0",
                         i, rom_addr, pix_valid, ea[i]);
            end
            step();
            tests++;
            if (pix_valid !== 1'b0) begin
                fails++;
                $display("FAIL mirror%0d_s2: v=%b want 0", i, pix_valid);
            end
            step();
            tests++;
            if (pix_valid !== 1'b1 || pix_out !== {4'd0, ea[i][7:0]}) begin
                fails++;
                $display("FAIL mirror%0d_s3: v=%b pix=%h want 1 %h",
                         i, pix_valid, pix_out, {4'd0, ea[i][7:0]});
            end
            step();
            tests++;
            if (pix_valid !== 1'b0) begin
                fails++;
                $display("FAIL mirror%0d_s4: v=%b want 0", i, pix_valid);
            end
        end
    endtask

    task automatic test_transparency();
        state = 3'b001;
        use_force = 1'b1;
        force_val = 12'h0F0;
        pix_x = 6'd5;
        pix_y = 7'd5;
        pix_req = 1'b1;
        step();
        pix_req = 1'b0;
        repeat (2) step();
        tests++;
        if (pix_valid !== 1'b1 || pix_opaque !== 1'b0) begin
            fails++;
            $display("FAIL transp: v=%b o=%b want 1 0", pix_valid, pix_opaque);
        end
        force_val = 12'hFFF;
        pix_req = 1'b1;
        step();
        pix_req = 1'b0;
        repeat (2) step();
        tests++;
        if (pix_valid !== 1'b1 || pix_opaque !== 1'b1 ||
            pix_out !== 12'hFFF) begin
            fails++;
            $display("FAIL opaque: v=%b o=%b pix=%h want 1 1 fff",
                     pix_valid, pix_opaque, pix_out);
        end
        for (int i = 0; i < 2; i++) begin
            pix_x = (i == 0) ? 6'd47 : 6'd3;
            pix_y = (i == 0) ? 7'd0 : 7'd64;
            pix_req = 1'b1;
            step();
            pix_req = 1'b0;
            repeat (2) step();
            tests++;
            if (pix_valid !== 1'b0 || pix_opaque !== 1'b0) begin
                fails++;
                $display("FAIL range%0d: v=%b o=%b want 0 0",
                         i, pix_valid, pix_opaque);
            end
        end
        use_force = 1'b0;
    endtask

    task automatic test_freeze();
        state = 3'b101;
        step();
        ticks(4);
        tests++;
        if (frame_idx !== 3'd1) begin
            fails++;
            $display("FAIL freeze_pre: frame=%0d want 1", frame_idx);
        end
        freeze = 1'b1;
        ticks(8);
        tests++;
        if (frame_idx !== 3'd1 || rom_bank !== 4'd5) begin
            fails++;
            $display("FAIL freeze_hold: frame=%0d bank=%0d want 1 5",
                     frame_idx, rom_bank);
        end
        state = 3'b001;
        step();
        tests++;
        if (frame_idx !== 3'd0 || rom_bank !== 4'd0) begin
            fails++;
            $display("FAIL freeze_change: frame=%0d bank=%0d want 0 0",
                     frame_idx, rom_bank);
        end
        freeze = 1'b0;
    endtask

    task automatic test_reset_mid();
        state = 3'b101;
        step();
        ticks(4);
        pix_x = 6'd1;
        pix_y = 7'd1;
        pix_req = 1'b1;
        repeat (3) step();
        tests++;
        if (pix_valid !== 1'b1 || frame_idx !== 3'd1) begin
            fails++;
            $display("FAIL mid_pre: v=%b frame=%0d want 1 1",
                     pix_valid, frame_idx);
        end
        rst = 1'b1;
        step();
        tests++;
        if (pix_valid !== 1'b0 || frame_idx !== 3'd0) begin
            fails++;
            $display("FAIL mid_rst: v=%b frame=%0d want 0 0",
                     pix_valid, frame_idx);
        end
        rst = 1'b0;
        pix_req = 1'b0;
        step();
        tests++;
        if (pix_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_drain: v=%b want 0", pix_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_tick = 1'b0;
        state = 3'b001;
        freeze = 1'b0;
        pix_x = '0;
        pix_y = '0;
        pix_req = 1'b0;
        test_reset();
        test_idle_loop();
        test_seq_change();
        test_jump();
        test_mirror();
        test_transparency();
        test_freeze();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
